exec_ctrl: RTL and testbench

EXEC_CTRL -- requirements
Module: exec_ctrl

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/reg_file.sv | 44 ++++
 rtl/exec_ctrl.sv | 132 +++++++++++++
 tb/tb_exec_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode, state and instruction-field definitions for the exec_ctrl slice.
package cpu_pkg;

    localparam int unsigned DATA_W  = 4;
    localparam int unsigned NREG    = 4;
    localparam int unsigned REG_AW  = 2;
    localparam int unsigned INSTR_W = 8;

    typedef enum logic [1:0] {
        OP_LDI = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_NOP = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_WB    = 2'b11
    } state_e;

    typedef struct packed {
        op_e               op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } instr_t;

    // LDI reuses the two source fields as a 4-bit immediate.
    function automatic logic [DATA_W-1:0] imm4(input instr_t i);
        return {i.rs1, i.rs2};
    endfunction

endpackage

// File: rtl/reg_file.sv
// 4x4 register file: one write port, operand captures loaded on request, async debug read.
module reg_file
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_load,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] rd2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
            rd1_q  <= '0;
            rd2_q  <= '0;
        end else begin
            if (we) begin
                regs_q[waddr] <= wdata;
            end
            // Captures hold their value until the next operand fetch.
            if (rd_load) begin
                rd1_q <= regs_q[rs1];
                rd2_q <= regs_q[rs2];
            end
        end
    end

    assign rd1      = rd1_q;
    assign rd2      = rd2_q;
    assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/exec_ctrl.sv
// Multi-cycle execution controller sequencing LDI/ADD/SUB/NOP through external add/sub units.
module exec_ctrl
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic               add_en,
    output logic               sub_en,
    output logic [DATA_W-1:0]  rd1,
    output logic [DATA_W-1:0]  rd2,
    input  logic [DATA_W-1:0]  add_result,
    input  logic               add_overflow,
    input  logic [DATA_W-1:0]  sub_result,
    input  logic               sub_overflow,
    output logic               done,
    output logic               ovf_flag,
    input  logic               ovf_clr,
    input  logic [REG_AW-1:0]  dbg_sel,
    output logic [DATA_W-1:0]  dbg_data
);

    state_e            state_q;
    instr_t            instr_q;
    instr_t            instr_w;
    logic [DATA_W-1:0] res_q;
    logic              ovf_q;
    logic              ready_q;
    logic              add_en_q;
    logic              sub_en_q;
    logic              done_q;
    logic              ovf_flag_q;
    logic              rf_we;
    logic              rf_load;

    assign instr_w = instr_t'(instr);

    // Control FSM; all handshake and enable outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            instr_q  <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b1;
            add_en_q <= 1'b0;
            sub_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr_w;
                        ready_q <= 1'b0;
                        case (instr_w.op)
                            OP_ADD, OP_SUB: begin
                                state_q <= ST_FETCH;
                            end
                            OP_LDI: begin
                                res_q   <= imm4(instr_w);
                                ovf_q   <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_WB;
                            end
                            OP_NOP: begin
                                ovf_q   <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_WB;
                            end
                        endcase
                    end
                end
                ST_FETCH: begin
                    add_en_q <= (instr_q.op == OP_ADD);
                    sub_en_q <= (instr_q.op == OP_SUB);
                    state_q  <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_q    <= (instr_q.op == OP_ADD) ? add_result : sub_result;
                    ovf_q    <= (instr_q.op == OP_ADD) ? add_overflow : sub_overflow;
                    add_en_q <= 1'b0;
                    sub_en_q <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= ST_WB;
                end
                ST_WB: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // A write-back that overflows takes priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_flag_q <= 1'b0;
        end else if ((state_q == ST_WB) && ovf_q) begin
            ovf_flag_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_flag_q <= 1'b0;
        end
    end

    assign rf_we   = (state_q == ST_WB) && (instr_q.op != OP_NOP);
    assign rf_load = (state_q == ST_FETCH);

    reg_file u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .rd_load  (rf_load),
        .rs1      (instr_q.rs1),
        .rs2      (instr_q.rs2),
        .we       (rf_we),
        .waddr    (instr_q.rd),
        .wdata    (res_q),
        .dbg_sel  (dbg_sel),
        .rd1      (rd1),
        .rd2      (rd2),
        .dbg_data (dbg_data)
    );

    assign instr_ready = ready_q;
    assign add_en      = add_en_q;
    assign sub_en      = sub_en_q;
    assign done        = done_q;
    assign ovf_flag    = ovf_flag_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: directed scenarios plus random instruction streams against a register-level model.
module tb_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       add_en;
    logic       sub_en;
    logic [3:0] rd1;
    logic [3:0] rd2;
    logic [3:0] add_result;
    logic       add_overflow;
    logic [3:0] sub_result;
    logic       sub_overflow;
    logic       done;
    logic       ovf_flag;
    logic       ovf_clr;
    logic [1:0] dbg_sel;
    logic [3:0] dbg_data;

    int         checks = 0;
    int         errors = 0;
    int         m [4];
    bit         exp_flag;
    logic [3:0] exp_rd1;
    logic [3:0] exp_rd2;
    bit         rand_clr;
    bit         force_clr_wb;
    int         accepts;

    always #5 clk = ~clk;

    exec_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .add_en       (add_en),
        .sub_en       (sub_en),
        .rd1          (rd1),
        .rd2          (rd2),
        .add_result   (add_result),
        .add_overflow (add_overflow),
        .sub_result   (sub_result),
        .sub_overflow (sub_overflow),
        .done         (done),
        .ovf_flag     (ovf_flag),
        .ovf_clr      (ovf_clr),
        .dbg_sel      (dbg_sel),
        .dbg_data     (dbg_data)
    );

    function automatic int sx(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    function automatic bit sovf(input int s);
        return (s > 7) || (s < -8);
    endfunction

    // External arithmetic units
    always_comb begin
        add_result   = 4'(rd1 + rd2);
        add_overflow = sovf(sx(rd1) + sx(rd2));
        sub_result   = 4'(rd1 - rd2);
        sub_overflow = sovf(sx(rd1) - sx(rd2));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_clr(input bit wb_ovf, input bit in_wb);
        bit clr;
        clr = (in_wb && force_clr_wb) || (rand_clr && ($urandom_range(0, 3) == 0));
        ovf_clr = clr;
        if (wb_ovf) exp_flag = 1'b1;
        else if (clr) exp_flag = 1'b0;
    endtask

    task automatic chk_idle();
        chk("ready_idle", 8'(instr_ready), 8'd1);
        chk("done_idle", 8'(done), 8'd0);
        chk("add_en_idle", 8'(add_en), 8'd0);
        chk("sub_en_idle", 8'(sub_en), 8'd0);
        chk("flag_idle", 8'(ovf_flag), 8'(exp_flag));
        chk("rd1_hold", 8'(rd1), 8'(exp_rd1));
        chk("rd2_hold", 8'(rd2), 8'(exp_rd2));
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            chk(tag, 8'(dbg_data), 8'(m[i]));
        end
    endtask

    // Issue one instruction from IDLE (at a falling edge) and follow it cycle by cycle.
    task automatic run_instr(input logic [1:0] op, input logic [1:0] rd,
                             input logic [1:0] rs1, input logic [1:0] rs2);
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        bit         ov;
        bit         we;
        chk_idle();
        a  = 4'(m[rs1]);
        b  = 4'(m[rs2]);
        we = 1'b1;
        ov = 1'b0;
        case (op)
            2'b00:   res = {rs1, rs2};
            2'b01: begin res = 4'(int'(a) + int'(b)); ov = sovf(sx(a) + sx(b)); end
            2'b10: begin res = 4'(int'(a) - int'(b)); ov = sovf(sx(a) - sx(b)); end
            default: begin res = 4'd0; we = 1'b0; end
        endcase
        instr       = {op, rd, rs1, rs2};
        instr_valid = 1'b1;
        drive_clr(1'b0, 1'b0);
        @(negedge clk);
        if (op == 2'b01 || op == 2'b10) begin
            chk("ready_fetch", 8'(instr_ready), 8'd0);
            chk("add_en_fetch", 8'(add_en), 8'd0);
            chk("sub_en_fetch", 8'(sub_en), 8'd0);
            chk("done_fetch", 8'(done), 8'd0);
            instr = 8'($urandom);
            drive_clr(1'b0, 1'b0);
            @(negedge clk);
            exp_rd1 = a;
            exp_rd2 = b;
            chk("add_en_exec", 8'(add_en), 8'(op == 2'b01));
            chk("sub_en_exec", 8'(sub_en), 8'(op == 2'b10));
            chk("rd1_exec", 8'(rd1), 8'(exp_rd1));
            chk("rd2_exec", 8'(rd2), 8'(exp_rd2));
            chk("ready_exec", 8'(instr_ready), 8'd0);
            chk("done_exec", 8'(done), 8'd0);
            instr = 8'($urandom);
            drive_clr(1'b0, 1'b0);
            @(negedge clk);
        end
        chk("done_wb", 8'(done), 8'd1);
        chk("ready_wb", 8'(instr_ready), 8'd0);
        chk("add_en_wb", 8'(add_en), 8'd0);
        chk("sub_en_wb", 8'(sub_en), 8'd0);
        dbg_sel = rd;
        #1;
        chk("dbg_wb_old", 8'(dbg_data), 8'(m[rd]));
        instr_valid = 1'b0;
        drive_clr(ov, 1'b1);
        if (we) m[rd] = int'(res);
        @(negedge clk);
        dbg_sel = rd;
        #1;
        chk("dbg_new", 8'(dbg_data), 8'(m[rd]));
        chk("done_after", 8'(done), 8'd0);
        chk("flag_after", 8'(ovf_flag), 8'(exp_flag));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m[i] = 0;
        exp_flag = 1'b0;
        exp_rd1  = 4'd0;
        exp_rd2  = 4'd0;
    endtask

    task automatic chk_reset_outs();
        chk("rst_add_en", 8'(add_en), 8'd0);
        chk("rst_sub_en", 8'(sub_en), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_rd1", 8'(rd1), 8'd0);
        chk("rst_rd2", 8'(rd2), 8'd0);
        chk("rst_flag", 8'(ovf_flag), 8'd0);
        chk_regs("rst_reg");
    endtask

    initial begin
        rst          = 1'b1;
        instr        = 8'd0;
        instr_valid  = 1'b0;
        ovf_clr      = 1'b0;
        dbg_sel      = 2'd0;
        rand_clr     = 1'b0;
        force_clr_wb = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_outs();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 8'(instr_ready), 8'd1);

        // LDI r1,7; LDI r2,3; SUB r0,r1,r2
        run_instr(2'b00, 2'd1, 2'b01, 2'b11);
        run_instr(2'b00, 2'd2, 2'b00, 2'b11);
        run_instr(2'b10, 2'd0, 2'd1, 2'd2);
        dbg_sel = 2'd0; #1;
        chk("sub_7_3", 8'(dbg_data), 8'h4);
        chk("sub_7_3_flag", 8'(ovf_flag), 8'd0);

        // LDI r2,8; SUB r3,r1,r2 overflows; then clear
        run_instr(2'b00, 2'd2, 2'b10, 2'b00);
        run_instr(2'b10, 2'd3, 2'd1, 2'd2);
        dbg_sel = 2'd3; #1;
        chk("sub_7_8", 8'(dbg_data), 8'hf);
        chk("sub_7_8_flag", 8'(ovf_flag), 8'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr  = 1'b0;
        exp_flag = 1'b0;
        chk("flag_cleared", 8'(ovf_flag), 8'd0);

        // LDI r2,1; ADD r1,r1,r2 -> 8 with overflow
        run_instr(2'b00, 2'd2, 2'b00, 2'b01);
        run_instr(2'b01, 2'd1, 2'd1, 2'd2);
        dbg_sel = 2'd1; #1;
        chk("add_7_1", 8'(dbg_data), 8'h8);
        chk("add_7_1_flag", 8'(ovf_flag), 8'd1);

        // Clear coincident with an overflowing write-back: set wins
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr  = 1'b0;
        exp_flag = 1'b0;
        force_clr_wb = 1'b1;
        run_instr(2'b10, 2'd3, 2'd1, 2'd2);
        force_clr_wb = 1'b0;
        chk("set_wins", 8'(ovf_flag), 8'd1);

        // Reset during EXEC of SUB r0,r1,r2
        instr       = 8'h86;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("abort_sub_en", 8'(sub_en), 8'd1);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        chk_reset_outs();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_abort", 8'(instr_ready), 8'd1);

        // ADD held valid for 10 cycles: one accept per IDLE visit
        instr       = 8'h70;
        instr_valid = 1'b1;
        accepts     = 0;
        for (int i = 0; i < 10; i++) begin
            chk("ready_pattern", 8'(instr_ready), 8'((i % 4) == 0));
            if (instr_ready) accepts++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("accept_count", 8'(accepts), 8'd3);
        repeat (2) @(negedge clk);

        // Random instruction stream with random flag clears
        rand_clr = 1'b1;
        repeat (40) begin
            run_instr(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
        end
        rand_clr = 1'b0;
        ovf_clr  = 1'b0;
        chk_regs("final_reg");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
